// File: rtl/mfp_uart_rx.sv
// 8N1 UART receiver (LSB first) with valid/ready holding register and
// framing-error / overrun pulses; feeds the serial memory loader.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | validating the start bit at half a bit time
// S_DATA  | sampling 8 data bits at mid-bit
// S_STOP  | sampling the stop bit, then deliver or flag framing error
// S_BREAK | stop bit was low; wait for the line to return high
module mfp_uart_rx #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 4) begin : g_cfg_check
      $error("mfp_uart_rx: CLKS_PER_BIT must be >= 4");
   end

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state, state_next;
   logic [1:0]    sync;
   logic          rx_s;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_idx, bit_next;
   logic [7:0]    shift;
   logic          sample_bit;
   logic          stop_ok;
   logic          stop_bad;
   logic          accept;

   assign rx_s   = sync[1];
   assign busy   = (state != S_IDLE);
   assign accept = rx_valid & rx_ready;

   always_comb begin
      state_next = state;
      bit_next   = bit_idx;
      sample_bit = 1'b0;
      stop_ok    = 1'b0;
      stop_bad   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) state_next = S_START;
         end
         S_START: begin
            if (cnt == CNT_HALF) begin
               state_next = rx_s ? S_IDLE : S_DATA;
               bit_next   = 3'd0;
            end
         end
         S_DATA: begin
            if (cnt == CNT_LAST) begin
               sample_bit = 1'b1;
               if (bit_idx == 3'd7) state_next = S_STOP;
               else                 bit_next   = bit_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (cnt == CNT_LAST) begin
               stop_ok    = rx_s;
               stop_bad   = ~rx_s;
               state_next = rx_s ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            if (rx_s) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      // Counter restarts on every state change and wraps once per bit in DATA.
      if (state_next != state || cnt == CNT_LAST) cnt_next = '0;
      else                                         cnt_next = cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync      <= 2'b11;
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         shift     <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sync      <= {sync[0], rx};
         state     <= state_next;
         cnt       <= cnt_next;
         bit_idx   <= bit_next;
         if (sample_bit) shift <= {rx_s, shift[7:1]};
         frame_err <= stop_bad;
         overrun   <= stop_ok & rx_valid & ~rx_ready;
         // A byte arriving on the accept cycle replaces the old one without a gap.
         if (stop_ok && (!rx_valid || rx_ready)) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
         end else if (accept) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
